// File: rtl/mem_stage.sv
// Memory pipeline stage: single outstanding data-memory access with ack timeout.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_read_data_2,
  input  logic [4:0]  i_write_register,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_to_reg,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_reg_write,
  output logic        o_mem_error,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_register
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [0:0]  state;
  logic [7:0]  busy_cnt;
  logic        cap_mem_to_reg;
  logic        cap_reg_write;
  logic [31:0] cap_alu;
  logic        is_mem;
  logic        misaligned;

  assign is_mem  = i_mem_read | i_mem_write;
  assign o_stall = (state == BUSY);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_mem & (i_alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy_cnt       <= '0;
      cap_mem_to_reg <= 1'b0;
      cap_reg_write  <= 1'b0;
      cap_alu        <= '0;
      o_dmem_req     <= 1'b0;
      o_dmem_we      <= 1'b0;
      o_dmem_addr    <= '0;
      o_dmem_wdata   <= '0;
      o_wb_valid     <= 1'b0;
      o_wb_reg_write <= 1'b0;
      o_mem_error    <= 1'b0;
      o_wb_data      <= '0;
      o_wb_register  <= '0;
    end else begin
      o_wb_valid     <= 1'b0;
      o_wb_reg_write <= 1'b0;
      o_mem_error    <= 1'b0;
      if (state == IDLE) begin
        if (i_valid) begin
          cap_mem_to_reg <= i_mem_to_reg;
          cap_reg_write  <= i_reg_write & (i_write_register != 5'd0);
          cap_alu        <= i_alu_result;
          o_wb_register  <= i_write_register;
          if (!is_mem || misaligned) begin
            o_wb_valid     <= 1'b1;
            o_wb_data      <= i_alu_result;
            o_wb_reg_write <= !misaligned & i_reg_write & (i_write_register != 5'd0);
            o_mem_error    <= misaligned;
          end else begin
            // a read+write combination is issued as a write
            state        <= BUSY;
            busy_cnt     <= 8'd1;
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= i_mem_write;
            o_dmem_addr  <= i_alu_result;
            o_dmem_wdata <= i_read_data_2;
          end
        end
      end else begin
        // ack wins over timeout when both land in the same cycle
        if (i_dmem_ack) begin
          state          <= IDLE;
          busy_cnt       <= '0;
          o_dmem_req     <= 1'b0;
          o_dmem_we      <= 1'b0;
          o_wb_valid     <= 1'b1;
          o_wb_reg_write <= cap_reg_write;
          o_wb_data      <= cap_mem_to_reg ? i_dmem_rdata : cap_alu;
        end else if (busy_cnt == TIMEOUT_CNT) begin
          state       <= IDLE;
          busy_cnt    <= '0;
          o_dmem_req  <= 1'b0;
          o_dmem_we   <= 1'b0;
          o_wb_valid  <= 1'b1;
          o_mem_error <= 1'b1;
          o_wb_data   <= cap_alu;
        end else begin
          busy_cnt <= busy_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, transaction-level random model,
// and hand-written reset/idle-ack sequences. Honours MEM_ALIGN_CHECK_EN.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_alu_result;
  logic [31:0] i_read_data_2;
  logic [4:0]  i_write_register;
  logic        i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg;
  logic        o_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_wb_valid, o_wb_reg_write, o_mem_error;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_register;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_alu_result(i_alu_result),
    .i_read_data_2(i_read_data_2), .i_write_register(i_write_register),
    .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_to_reg(i_mem_to_reg), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .o_wb_valid(o_wb_valid),
    .o_wb_reg_write(o_wb_reg_write), .o_mem_error(o_mem_error), .o_wb_data(o_wb_data),
    .o_wb_register(o_wb_register)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  rd;
    bit          rw, mr, mw, mtr;
    int unsigned ack_at;   // BUSY cycle (1-based) in which ack is driven; > TO means never
    logic [31:0] rdata;
    int unsigned busy;     // expected number of stalled cycles
    logic [31:0] exp_data;
    bit          exp_rw;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] rd,
                              input bit rw, input bit mr, input bit mw, input bit mtr,
                              input int unsigned ack_at, input logic [31:0] rdata,
                              input int unsigned busy, input logic [31:0] exp_data,
                              input bit exp_rw, input bit exp_err);
    vec_t v;
    v.alu = alu; v.rd2 = rd2; v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw; v.mtr = mtr;
    v.ack_at = ack_at; v.rdata = rdata; v.busy = busy; v.exp_data = exp_data;
    v.exp_rw = exp_rw; v.exp_err = exp_err;
    return v;
  endfunction

  // Reference model: derive the whole transaction outcome from the operation description.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit mem = v.mr | v.mw;
    bit mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = mem && (v.alu % 4 != 0);
`endif
    if (!mem || mis) begin
      r.busy = 0; r.exp_data = v.alu; r.exp_err = mis;
      r.exp_rw = !mis && v.rw && (v.rd != 0);
    end else if (v.ack_at <= TO) begin
      r.busy = v.ack_at; r.exp_data = v.mtr ? v.rdata : v.alu;
      r.exp_err = 1'b0; r.exp_rw = v.rw && (v.rd != 0);
    end else begin
      r.busy = TO; r.exp_data = v.alu; r.exp_err = 1'b1; r.exp_rw = 1'b0;
    end
    return r;
  endfunction

  // Entry and exit points are 1 time unit after a rising edge with the DUT in IDLE.
  task automatic apply(input vec_t v, input bit back2back);
    chk("entry_stall", o_stall, 0);
    i_valid = 1'b1; i_alu_result = v.alu; i_read_data_2 = v.rd2; i_write_register = v.rd;
    i_reg_write = v.rw; i_mem_read = v.mr; i_mem_write = v.mw; i_mem_to_reg = v.mtr;
    i_dmem_ack = 1'($urandom_range(0, 1));
    i_dmem_rdata = $urandom;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int unsigned c = 1; c <= v.busy; c++) begin
      chk("busy_stall", o_stall, 1);
      chk("busy_req", o_dmem_req, 1);
      chk("busy_we", o_dmem_we, v.mw);
      chk("busy_addr", o_dmem_addr, v.alu);
      chk("busy_wdata", o_dmem_wdata, v.rd2);
      chk("busy_wb_valid", o_wb_valid, 0);
      i_valid = 1'($urandom_range(0, 1));
      i_alu_result = $urandom; i_read_data_2 = $urandom;
      i_write_register = 5'($urandom); i_mem_read = 1'($urandom); i_mem_write = 1'($urandom);
      i_dmem_ack = (c == v.ack_at);
      i_dmem_rdata = (c == v.ack_at) ? v.rdata : $urandom;
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_dmem_ack = 1'b0;
    chk("wb_valid", o_wb_valid, 1);
    chk("wb_stall", o_stall, 0);
    chk("wb_req", o_dmem_req, 0);
    chk("wb_err", o_mem_error, v.exp_err);
    chk("wb_reg_write", o_wb_reg_write, v.exp_rw);
    chk("wb_register", o_wb_register, v.rd);
    if (!v.exp_err) chk("wb_data", o_wb_data, v.exp_data);
    if (!back2back) begin
      i_dmem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      i_dmem_ack = 1'b0;
      chk("pulse_wb_valid", o_wb_valid, 0);
      chk("pulse_err", o_mem_error, 0);
      chk("idle_req", o_dmem_req, 0);
    end
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_alu_result = '0; i_read_data_2 = '0;
    i_write_register = '0; i_reg_write = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_mem_to_reg = 1'b0; i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", o_stall, 0);
    chk("rst_req", o_dmem_req, 0);
    chk("rst_wb_valid", o_wb_valid, 0);
    chk("rst_err", o_mem_error, 0);
    chk("rst_wb_data", o_wb_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    vecs.push_back(mk(32'h15, 32'h0, 5'd8, 1, 0, 0, 0, 0, 32'h0, 0, 32'h15, 1, 0));
    vecs.push_back(mk(32'h100, 32'h0, 5'd9, 1, 1, 0, 1, 4, 32'hDEADBEEF, 4, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(32'h40, 32'h1234, 5'd0, 0, 0, 1, 0, 2, 32'h0, 2, 32'h40, 0, 0));
    vecs.push_back(mk(32'h80, 32'h0, 5'd3, 1, 1, 0, 1, TO + 1, 32'h0, TO, 32'h80, 0, 1));
    vecs.push_back(mk(32'h84, 32'h0, 5'd4, 1, 1, 0, 1, TO, 32'hCAFEF00D, TO, 32'hCAFEF00D, 1, 0));
    vecs.push_back(mk(32'h77, 32'h0, 5'd0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h77, 0, 0));
    vecs.push_back(mk(32'h200, 32'h55, 5'd5, 1, 1, 1, 0, 1, 32'h9, 1, 32'h200, 1, 0));
`ifdef MEM_ALIGN_CHECK_EN
    vecs.push_back(mk(32'h102, 32'h0, 5'd6, 1, 1, 0, 1, 1, 32'h11, 0, 32'h102, 0, 1));
`else
    vecs.push_back(mk(32'h102, 32'h0, 5'd6, 1, 1, 0, 1, 1, 32'h11, 1, 32'h11, 1, 0));
`endif
    foreach (vecs[i]) apply(vecs[i], 1'b0);

    // reset in the middle of a BUSY access, followed by a stray late ack
    i_valid = 1'b1; i_alu_result = 32'h300; i_read_data_2 = 32'h0; i_write_register = 5'd7;
    i_reg_write = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_mem_to_reg = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("pre_rst_req", o_dmem_req, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", o_dmem_req, 0);
    chk("mid_rst_stall", o_stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h5A5A5A5A;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("late_ack_wb_valid", o_wb_valid, 0);
      chk("late_ack_req", o_dmem_req, 0);
      chk("late_ack_stall", o_stall, 0);
    end
    i_dmem_ack = 1'b0;

    for (int n = 0; n < 200; n++) begin
      vec_t v;
      v.alu = $urandom;
      if ($urandom_range(0, 7) != 0) v.alu[1:0] = 2'b00;
      v.rd2 = $urandom; v.rd = 5'($urandom); v.rw = 1'($urandom);
      v.mr = 1'($urandom); v.mw = 1'($urandom); v.mtr = 1'($urandom);
      v.ack_at = $urandom_range(1, TO + 1); v.rdata = $urandom;
      v.busy = 0; v.exp_data = '0; v.exp_rw = 1'b0; v.exp_err = 1'b0;
      apply(model(v), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles in BUSY waiting for i_dmem_ack (range 1-255).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_valid  input  1  EX result present this cycle.
REQ-005 i_alu_result  input  32  ALU result, or effective address for memory operations.
REQ-006 i_read_data_2  input  32  store data (rt).
REQ-007 i_write_register  input  5  destination register.
REQ-008 i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  input  1 each  control from EX.
REQ-009 o_stall  output  1  upstream holds its outputs and re-presents them while high.
REQ-010 o_dmem_req, o_dmem_we  output  1 each  data-memory request and write enable.
REQ-011 o_dmem_addr, o_dmem_wdata  output  32 each  data-memory address and write data.
REQ-012 i_dmem_ack  input  1  memory completion; i_dmem_rdata  input  32  load data, valid with ack.
REQ-013 o_wb_valid, o_wb_reg_write, o_mem_error  output  1 each; o_wb_data  output  32; o_wb_register  output  5.

Function
REQ-014 SHALL implement the FSM states IDLE and BUSY.
REQ-015 In IDLE, i_valid with neither mem_read nor mem_write SHALL produce o_wb_valid=1 on the next cycle, with o_wb_data=i_alu_result (1-cycle latency).
REQ-016 In IDLE, i_valid with mem_read or mem_write SHALL capture all inputs, assert o_dmem_req on the next cycle with o_dmem_we=mem_write, o_dmem_addr=alu_result and o_dmem_wdata=read_data_2, and enter BUSY.
REQ-017 If mem_read and mem_write are both set, the access SHALL be treated as a write.
REQ-018 o_stall SHALL equal (state==BUSY), combinationally; i_valid SHALL be ignored while o_stall=1.
REQ-019 In BUSY, req, we, addr and wdata SHALL remain stable until i_dmem_ack is sampled high.
REQ-020 On ack, the next cycle SHALL have o_dmem_req=0, o_wb_valid=1, o_wb_data=rdata if mem_to_reg else alu_result, and state IDLE; a back-to-back new request MAY start in that same cycle.
REQ-021 The BUSY cycle counter SHALL reach TIMEOUT without ack to abort: req drops, o_mem_error=1 and o_wb_valid=1 with o_wb_reg_write=0 for one cycle, then IDLE.
REQ-022 Ack in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-023 i_dmem_ack in IDLE SHALL be ignored.
REQ-024 o_wb_reg_write SHALL be captured reg_write AND (write_register != 0).
REQ-025 o_wb_register SHALL be the captured write_register.
REQ-026 o_wb_valid and o_mem_error SHALL be single-cycle pulses per operation.

Reset
REQ-027 Reset SHALL force state IDLE, clear the counter, and set all outputs to 0 asynchronously, including o_dmem_req mid-BUSY.
REQ-028 After reset deasserts, an in-flight ack SHALL be ignored and no wb pulse SHALL issue for an aborted operation.

Configuration
REQ-029 With MEM_ALIGN_CHECK_EN defined, a memory operation with alu_result[1:0]!=0 SHALL issue no request, stay in IDLE, and produce o_mem_error=1 and o_wb_valid=1 with o_wb_reg_write=0 on the next cycle.
REQ-030 Without MEM_ALIGN_CHECK_EN, the address SHALL pass unmodified and no alignment error SHALL exist.

Verification
REQ-031 ALU op: alu_result=0x15, rd=8, reg_write=1 -> next cycle wb_valid=1, data=0x15, register=8, no req.
REQ-032 Load from 0x100 with ack after 3 cycles and rdata=0xDEADBEEF -> stall high 4 cycles, req stable, then wb data=0xDEADBEEF, register=rt.
REQ-033 Store: addr 0x40, wdata 0x1234, ack after 1 cycle -> we=1, wb_valid=1, wb_reg_write=0.
REQ-034 TIMEOUT=4 with no ack -> req for 4 cycles, then mem_error and wb_valid pulse with reg_write=0, then IDLE; ack on the 4th cycle -> success.
REQ-035 Reset asserted mid-BUSY -> req=0 and stall=0 immediately, late ack ignored; ALU op with write_register=0 -> wb_reg_write=0.
REQ-036 With MEM_ALIGN_CHECK_EN, load from 0x102 -> no req, mem_error pulse next cycle; without the macro, req with addr 0x102.
